// File: rtl/mult_matrix_skew_pkg.sv
// Shared matrix package: FSM state encoding and lane bit-slice placement.
// Used by mult_matrix_skew and mult_matrix_revert.
package mult_matrix_skew_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } mm_state_e;

  // LSB of lane `lane` in a packed row; lane 0 occupies the most significant slice.
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned dw,
                                           input int unsigned lanes);
    return (lanes - 1 - lane) * dw;
  endfunction

endpackage

// File: rtl/skew_lane_delay.sv
// Per-lane delay line of `depth` advance steps with zero injection.
// Ports: clk, rst_n (async active-low), adv_i (advance enable),
//        zero_i (replace din_i with zero), din_i (lane input), dout_o (delayed lane).
// depth = 0 is a pure (zero-masked) pass-through.
module skew_lane_delay #(
  parameter int unsigned data_size = 4,
  parameter int unsigned depth     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adv_i,
  input  logic                 zero_i,
  input  logic [data_size-1:0] din_i,
  output logic [data_size-1:0] dout_o
);

  logic [data_size-1:0] lane_in_c;
  assign lane_in_c = zero_i ? '0 : din_i;

  if (depth == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, adv_i};
    assign dout_o    = lane_in_c;
  end else begin : g_shift
    logic [depth-1:0][data_size-1:0] sr_q, sr_d;

    // Shift by one slot on every advance step; otherwise hold.
    always_comb begin
      sr_d = sr_q;
      if (adv_i) begin
        sr_d[0] = lane_in_c;
        for (int unsigned k = 1; k < depth; k++) begin
          sr_d[k] = sr_q[k-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else        sr_q <= sr_d;
    end

    assign dout_o = sr_q[depth-1];
  end

endmodule

// File: rtl/mult_matrix_skew.sv
// Diagonal skew of a row stream: lane c is delayed by c advance steps, then all
// lanes share one output register. After the last row, size-1 DRAIN cycles
// push zeros through to flush the staircase.
// Ports: clk, rst_n (async active-low), in_row/in_valid/in_last/in_ready (row input),
//        output_stream/out_valid (skewed beats, no backpressure), busy (FEED or DRAIN).
module mult_matrix_skew
  import mult_matrix_skew_pkg::*;
#(
  parameter int unsigned data_size = 4,
  parameter int unsigned size      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [data_size*size-1:0] in_row,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [data_size*size-1:0] output_stream,
  output logic                      out_valid,
  output logic                      busy
);

  localparam int unsigned W          = data_size * size;
  localparam int unsigned CNT_W      = (size > 1) ? $clog2(size) : 1;
  localparam int unsigned DRAIN_LAST = (size > 1) ? size - 2 : 0;

  mm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     stream_q, stream_d;
  logic             valid_q, busy_q;
  logic             advance_c, zero_c;
  logic [W-1:0]     lane_out_c;

  // Ready is a pure state decode so upstream sees it in the same cycle.
  assign in_ready = (state_q != ST_DRAIN);

  // Next-state, drain counter and advance/zero-inject control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    advance_c = 1'b0;
    zero_c    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_FEED: begin
        if (in_valid) begin
          advance_c = 1'b1;
          if (in_last) begin
            cnt_d   = '0;
            state_d = (size > 1) ? ST_DRAIN : ST_IDLE;
          end else begin
            state_d = ST_FEED;
          end
        end
      end
      ST_DRAIN: begin
        advance_c = 1'b1;
        zero_c    = 1'b1;
        if (cnt_q == CNT_W'(DRAIN_LAST)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bubbles hold the output bus; only an advance step loads it.
  assign stream_d = advance_c ? lane_out_c : stream_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      stream_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stream_q <= stream_d;
      valid_q  <= advance_c;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  // One delay line per lane, depth equal to the lane index.
  for (genvar c = 0; c < int'(size); c++) begin : g_lane
    skew_lane_delay #(
      .data_size (data_size),
      .depth     (c)
    ) u_delay (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_i  (advance_c),
      .zero_i (zero_c),
      .din_i  (in_row[lane_lsb(c, data_size, size) +: data_size]),
      .dout_o (lane_out_c[lane_lsb(c, data_size, size) +: data_size])
    );
  end

  assign output_stream = stream_q;
  assign out_valid     = valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mult_matrix_skew.sv
// Directed bench for mult_matrix_skew (size = 3, data_size = 4).
module tb_mult_matrix_skew;

  logic        clk;
  logic        rst_n;
  logic [11:0] in_row;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [11:0] output_stream;
  logic        out_valid;
  logic        busy;

  int n_checks;
  int n_fail;

  mult_matrix_skew #(.data_size(4), .size(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_row        (in_row),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .output_stream (output_stream),
    .out_valid     (out_valid),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane 0 sits in the most significant nibble.
  function automatic logic [11:0] p(input logic [3:0] c0, input logic [3:0] c1,
                                    input logic [3:0] c2);
    return {c0, c1, c2};
  endfunction

  task automatic chk(input string tag, input logic [11:0] eo, input logic ev,
                     input logic er, input logic eb);
    n_checks++;
    assert (output_stream === eo) else begin
      n_fail++;
      $error("FAIL %s stream: observed %h expected %h", tag, output_stream, eo);
    end
    n_checks++;
    assert (out_valid === ev) else begin
      n_fail++;
      $error("FAIL %s out_valid: observed %b expected %b", tag, out_valid, ev);
    end
    n_checks++;
    assert (in_ready === er) else begin
      n_fail++;
      $error("FAIL %s in_ready: observed %b expected %b", tag, in_ready, er);
    end
    n_checks++;
    assert (busy === eb) else begin
      n_fail++;
      $error("FAIL %s busy: observed %b expected %b", tag, busy, eb);
    end
  endtask

  // Drive one cycle of input, clock it, then check the following cycle.
  task automatic beat(input logic v, input logic l, input logic [11:0] row,
                      input logic [11:0] eo, input logic ev, input logic er,
                      input logic eb, input string tag);
    in_valid = v;
    in_last  = l;
    in_row   = row;
    @(posedge clk);
    #1;
    chk(tag, eo, ev, er, eb);
  endtask

  // 3x3 matrix 1..9, rows at consecutive cycles.
  task automatic run_basic(input string pfx);
    beat(1, 0, p(1, 2, 3), p(1, 0, 0), 1, 1, 1, {pfx, "c1"});
    beat(1, 0, p(4, 5, 6), p(4, 2, 0), 1, 1, 1, {pfx, "c2"});
    beat(1, 1, p(7, 8, 9), p(7, 5, 3), 1, 0, 1, {pfx, "c3"});
    beat(0, 0, p(0, 0, 0), p(0, 8, 6), 1, 0, 1, {pfx, "c4"});
    beat(0, 0, p(0, 0, 0), p(0, 0, 9), 1, 1, 0, {pfx, "c5"});
    beat(0, 0, p(0, 0, 0), p(0, 0, 9), 0, 1, 0, {pfx, "c6"});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_row   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 12'h000, 0, 1, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle", 12'h000, 0, 1, 0);

    run_basic("basic_");

    // Bubble at cycle 1 (with a stray in_last that must be ignored).
    beat(1, 0, p(1, 2, 3), p(1, 0, 0), 1, 1, 1, "bub_c1");
    beat(0, 1, p(15, 15, 15), p(1, 0, 0), 0, 1, 1, "bub_c2");
    beat(1, 0, p(4, 5, 6), p(4, 2, 0), 1, 1, 1, "bub_c3");
    beat(1, 1, p(7, 8, 9), p(7, 5, 3), 1, 0, 1, "bub_c4");
    beat(0, 0, p(0, 0, 0), p(0, 8, 6), 1, 0, 1, "bub_c5");
    beat(0, 0, p(0, 0, 0), p(0, 0, 9), 1, 1, 0, "bub_c6");
    beat(0, 0, p(0, 0, 0), p(0, 0, 9), 0, 1, 0, "bub_c7");

    // Single-row matrix.
    beat(1, 1, p(10, 11, 12), p(10, 0, 0), 1, 0, 1, "one_c1");
    beat(0, 0, p(0, 0, 0), p(0, 11, 0), 1, 0, 1, "one_c2");
    beat(0, 0, p(0, 0, 0), p(0, 0, 12), 1, 1, 0, "one_c3");
    beat(0, 0, p(0, 0, 0), p(0, 0, 12), 0, 1, 0, "one_c4");

    // Back-to-back matrices; second matrix's first row held during DRAIN.
    beat(1, 0, p(1, 2, 3), p(1, 0, 0), 1, 1, 1, "b2b_c1");
    beat(1, 0, p(4, 5, 6), p(4, 2, 0), 1, 1, 1, "b2b_c2");
    beat(1, 1, p(7, 8, 9), p(7, 5, 3), 1, 0, 1, "b2b_c3");
    beat(1, 0, p(10, 11, 12), p(0, 8, 6), 1, 0, 1, "b2b_c4");
    beat(1, 0, p(10, 11, 12), p(0, 0, 9), 1, 1, 0, "b2b_c5");
    beat(1, 0, p(10, 11, 12), p(10, 0, 0), 1, 1, 1, "b2b_c6");
    beat(1, 0, p(13, 14, 15), p(13, 11, 0), 1, 1, 1, "b2b_c7");
    beat(1, 1, p(1, 2, 3), p(1, 14, 12), 1, 0, 1, "b2b_c8");
    beat(0, 0, p(0, 0, 0), p(0, 2, 15), 1, 0, 1, "b2b_c9");
    beat(0, 0, p(0, 0, 0), p(0, 0, 3), 1, 1, 0, "b2b_c10");
    beat(0, 0, p(0, 0, 0), p(0, 0, 3), 0, 1, 0, "b2b_c11");

    // Reset during the first DRAIN cycle.
    beat(1, 0, p(1, 2, 3), p(1, 0, 0), 1, 1, 1, "rst_c1");
    beat(1, 0, p(4, 5, 6), p(4, 2, 0), 1, 1, 1, "rst_c2");
    beat(1, 1, p(7, 8, 9), p(7, 5, 3), 1, 0, 1, "rst_c3");
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_mid", 12'h000, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("rst_hold", 12'h000, 0, 1, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_basic("post_rst_");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_matrix_skew.md
MULT_MATRIX_SKEW -- requirements
Module: mult_matrix_skew

Interface
REQ-001 Parameter data_size, default 4, width in bits of one matrix element.
REQ-002 Parameter size, default 3, number of columns (lanes) per row; 1 <= size <= 16.
REQ-003 Port clk  input  1  the only clock; all state is updated on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_row  input  data_size*size  one matrix row; column c sits at bits [(size-c)*data_size-1 -: data_size].
REQ-006 Port in_valid  input  1  in_row holds a valid row this cycle.
REQ-007 Port in_last  input  1  qualifies in_valid and marks the final row of the current matrix.
REQ-008 Port in_ready  output  1  the block can accept a row this cycle.
REQ-009 Port output_stream  output  data_size*size  skewed (diagonal-staggered) bus, using the same lane packing as in_row.
REQ-010 Port out_valid  output  1  output_stream carries a valid skewed beat.
REQ-011 Port busy  output  1  high in FEED and DRAIN states.

Function
REQ-012 States are IDLE, FEED and DRAIN; the reset state is IDLE.
REQ-013 A row is accepted on a clock edge when in_valid and in_ready are both high.
REQ-014 in_ready is high in IDLE and FEED and low in DRAIN; it is decoded combinationally from the state.
REQ-015 Lane c is delayed by c advance steps through a per-lane shift register of depth c, followed by one common output register; an element of row r appears on lane c exactly 1+c advance steps after acceptance.
REQ-016 An advance step occurs on an accepted beat or on any DRAIN cycle, and on no other cycle.
REQ-017 In FEED, a cycle with in_valid low is a bubble: the shift registers and output_stream hold their values, and out_valid is 0 on the next cycle.
REQ-018 out_valid is registered; it is 1 in the cycle after each advance step and 0 otherwise.
REQ-019 Transitions: IDLE to FEED on an accepted non-last row. IDLE or FEED to DRAIN on an accepted row with in_last = 1, provided size > 1. IDLE or FEED to IDLE on an accepted row with in_last = 1 when size = 1.
REQ-020 DRAIN lasts exactly size-1 cycles, counted by a drain counter of width clog2(size); each DRAIN cycle injects zeros into all lane inputs; DRAIN then returns to IDLE.
REQ-021 An N-row matrix produces exactly N+size-1 out_valid beats, which is 2*size-1 beats for a square matrix.
REQ-022 in_valid while in_ready = 0 is ignored and causes no state change; in_last without in_valid is ignored.
REQ-023 There is no downstream backpressure; the consumer must sample every beat on which out_valid = 1.
REQ-024 The block performs no arithmetic; data passes through bit-exact, and all injected padding is all-zero.

Reset
REQ-025 While rst_n = 0: state = IDLE, all shift registers = 0, output_stream = 0, out_valid = 0, busy = 0, drain counter = 0; in_ready reads 1 (decoded from IDLE).
REQ-026 Reset asserted mid-FEED or mid-DRAIN discards all in-flight data; the first row accepted after release starts a new matrix.

Structure
REQ-027 The state encoding (IDLE/FEED/DRAIN) and the lane bit-slice offset function belong in the shared matrix package, which mult_matrix_revert also uses.
REQ-028 One sub-module, skew_lane_delay, is parameterised by data_size and depth; it has an advance enable and a zero-inject input, is instantiated once per lane, and is a pass-through when depth = 0.

Verification (size = 3, data_size = 4; lanes listed as c0,c1,c2)
REQ-029 Rows [1,2,3], [4,5,6], [7,8,9] accepted at cycles 0-2 with in_last at cycle 2 -> output_stream is 1,0,0 / 4,2,0 / 7,5,3 / 0,8,6 / 0,0,9 at cycles 1-5; out_valid is high at cycles 1-5 only; in_ready is low at cycles 3-4.
REQ-030 Same stimulus with in_valid low at cycle 1 (rows at cycles 0, 2 and 3) -> out_valid is 0 at cycle 2, output_stream holds 1,0,0 at cycle 2, and the beat sequence is otherwise identical, shifted by one cycle.
REQ-031 Single row [A,B,C] with in_last -> beats A,0,0 / 0,B,0 / 0,0,C, then IDLE.
REQ-032 Two matrices offered back-to-back with in_valid held high -> in_ready is low for exactly 2 DRAIN cycles; the second matrix's first row is accepted the cycle after DRAIN ends, and no beats are lost or merged.
REQ-033 rst_n pulsed low during the first DRAIN cycle -> output_stream = 0, out_valid = 0 and state = IDLE immediately; a subsequent matrix reproduces the REQ-029 sequence exactly.
REQ-034 Chaining mult_matrix_skew directly into mult_matrix_revert with random 4-bit 3x3 matrices -> the original rows are recovered in order; 1000 matrices with zero mismatches.
